// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FSM encoding and index-width helper for FIFO-side schedulers.
package fifo_ctrl_pkg;
    typedef enum logic {ST_ARB = 1'b0, ST_WRITE = 1'b1} state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer request bus plus FIFO write port seen by the arbiter.
interface fifo_write_arbiter_if import fifo_ctrl_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IW = idx_width(NUM_REQ);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic                          fifo_write_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic [IW-1:0]                 grant_id;
    logic                          busy;
    logic                          stall;

    modport master (
        output req, req_data, fifo_full,
        input  ack, fifo_write_en, fifo_data_in, grant_id, busy, stall
    );

    modport slave (
        input  req, req_data, fifo_full,
        output ack, fifo_write_en, fifo_data_in, grant_id, busy, stall
    );
endinterface

// File: rtl/fifo_write_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching from last+1 and wrapping.
module rr_arbiter import fifo_ctrl_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    // Walk the ring backwards so the closest requester after last is assigned last and wins.
    always_comb begin
        grant = '0;
        idx   = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                grant = NUM_REQ'(1) << ((int'(last) + k) % NUM_REQ);
                idx   = IW'((int'(last) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one edge-triggered FIFO write port,
// one registered write pulse per grant followed by a forced idle cycle.
module fifo_write_arbiter import fifo_ctrl_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic                clock,
    input logic                reset_n,
    fifo_write_arbiter_if.slave bus
);
    localparam int IW = idx_width(NUM_REQ);

    state_t                  state, state_next;
    logic                    go;
    logic [NUM_REQ-1:0]      grant, ack_q;
    logic [IW-1:0]           win, grant_id_q;
    logic [DATA_WIDTH-1:0]   data_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req   (bus.req),
        .last  (grant_id_q),
        .grant (grant),
        .idx   (win)
    );

    always_comb begin
        go         = (state == ST_ARB) && |bus.req && !bus.fifo_full;
        state_next = go ? ST_WRITE : ST_ARB;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ARB;
            ack_q      <= '0;
            data_q     <= '0;
            grant_id_q <= IW'(NUM_REQ - 1);
        end else begin
            state <= state_next;
            ack_q <= go ? grant : '0;
            if (go) begin
                data_q     <= bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
                grant_id_q <= win;
            end
        end
    end

    // The write pulse is exactly the WRITE state, so it is a flop output with no extra logic.
    assign bus.fifo_write_en = (state == ST_WRITE);
    assign bus.busy          = (state == ST_WRITE);
    assign bus.ack           = ack_q;
    assign bus.fifo_data_in  = data_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.stall         = (state == ST_ARB) && |bus.req && bus.fifo_full;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random stimulus against a ring-scan reference model
// of the arbiter plus a queue model of a 16-deep edge-triggered FIFO.
module tb_fifo_write_arbiter;
    localparam int N = 4, DW = 8, DEPTH = 16;

    logic clock = 0, reset_n = 0;
    logic force_full = 0, rd = 0, flush = 0, we_prev = 0;
    int cnt = 0, checks = 0, errors = 0;
    bit cmp_en = 0;
    logic [DW-1:0] fq[$];
    logic          m_wr;
    logic [N-1:0]  m_ack;
    logic [DW-1:0] m_data;
    logic [1:0]    m_gid;

    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;
    assign bus.fifo_full = force_full || (cnt >= DEPTH);

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    // FIFO model: stores on each rising edge of write enable, pops on rd.
    always @(posedge clock) begin
        we_prev <= bus.fifo_write_en;
        if (flush) fq.delete();
        else begin
            if (bus.fifo_write_en && !we_prev && fq.size() < DEPTH) fq.push_back(bus.fifo_data_in);
            if (rd && fq.size() > 0) void'(fq.pop_front());
        end
        cnt <= fq.size();
    end

    // Reference: after a write cycle always idle; otherwise grant the next requester round the ring.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_wr <= 0; m_ack <= '0; m_data <= '0; m_gid <= 2'(N - 1);
        end else if (m_wr) begin
            m_wr <= 0; m_ack <= '0;
        end else if (|bus.req && !bus.fifo_full) begin
            m_wr   <= 1;
            m_ack  <= N'(1) << rr_pick(bus.req, int'(m_gid));
            m_data <= bus.req_data[rr_pick(bus.req, int'(m_gid))*DW +: DW];
            m_gid  <= 2'(rr_pick(bus.req, int'(m_gid)));
        end else begin
            m_ack <= '0;
        end
    end

    always @(negedge clock) if (cmp_en) begin
        chk("write_en", 32'(bus.fifo_write_en), 32'(m_wr));
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("data", 32'(bus.fifo_data_in), 32'(m_data));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("busy", 32'(bus.busy), 32'(m_wr));
        chk("stall", 32'(bus.stall), 32'(!m_wr && |bus.req && bus.fifo_full));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        bus.req = '0; force_full = 0; rd = 0; flush = 1; reset_n = 0;
        step(1);
        reset_n = 1; flush = 0;
    endtask

    initial begin
        int got[$];
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [DW-1:0] exp_d[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        int n, w, acks, ack2;
        bus.req = '0; bus.req_data = '0;
        #12;
        chk("rst_we", 32'(bus.fifo_write_en), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_data", 32'(bus.fifo_data_in), 0);
        chk("rst_gid", 32'(bus.grant_id), 3);
        chk("rst_busy", 32'(bus.busy), 0);
        reset_n = 1; cmp_en = 1;
        step(1);
        // Single producer, one word
        bus.req_data[7:0] = 8'hA5; bus.req = 4'b0001;
        step(1);
        chk("a5_ack", 32'(bus.ack), 1);
        chk("a5_we", 32'(bus.fifo_write_en), 1);
        chk("a5_gid", 32'(bus.grant_id), 0);
        bus.req = '0;
        step(1);
        chk("a5_cnt", 32'(fq.size()), 1);
        chk("a5_fifo", 32'(fq.size() > 0 ? fq[0] : 8'h00), 32'hA5);
        // All four held: rotating order
        do_reset();
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'(8'h10 + i);
        bus.req = 4'b1111;
        for (int i = 0; i < 20 && got.size() < 5; i++) begin
            step(1);
            if (bus.fifo_write_en) got.push_back(int'(bus.grant_id));
        end
        bus.req = '0;
        step(1);
        chk("rr_count", 32'(got.size()), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(i < got.size() ? got[i] : -1), 32'(exp_g[i]));
            chk("rr_fifo", 32'(i < fq.size() ? fq[i] : 8'hxx), 32'(exp_d[i]));
        end
        // Full stalls grants
        do_reset();
        force_full = 1; bus.req = 4'b0010; n = 0; w = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n += int'(bus.fifo_write_en);
            w += int'(bus.stall);
        end
        chk("full_no_we", 32'(n), 0);
        chk("full_stall", 32'(w), 10);
        force_full = 0; w = 0;
        for (int i = 0; i < 2 && w == 0; i++) begin
            step(1);
            w = int'(bus.fifo_write_en);
        end
        chk("unfull_we", 32'(w), 1);
        bus.req = '0;
        step(1);
        chk("unfull_stall", 32'(bus.stall), 0);
        // Fill the FIFO from two producers
        do_reset();
        bus.req_data = 32'($urandom);
        bus.req = 4'b0101; acks = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (|bus.ack) acks++;
        end
        chk("fill_acks", 32'(acks), 16);
        chk("fill_stall", 32'(bus.stall), 1);
        rd = 1;
        step(1);
        rd = 0; acks = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (|bus.ack) acks++;
        end
        chk("drain1_acks", 32'(acks), 1);
        // Reset during WRITE
        do_reset();
        bus.req = 4'b0001;
        step(1);
        chk("pre_rst_we", 32'(bus.fifo_write_en), 1);
        #1 reset_n = 0;
        #1;
        chk("mid_rst_we", 32'(bus.fifo_write_en), 0);
        chk("mid_rst_ack", 32'(bus.ack), 0);
        bus.req = '0;
        step(1);
        reset_n = 1;
        chk("post_rst_gid", 32'(bus.grant_id), 3);
        bus.req = 4'b0110;
        step(1);
        chk("post_rst_grant", 32'(bus.grant_id), 1);
        chk("post_rst_ack", 32'(bus.ack), 32'b0010);
        bus.req = '0;
        // Short req pulse during another WRITE is not served
        do_reset();
        bus.req = 4'b0001;
        step(1);
        bus.req = 4'b0101; ack2 = 0;
        step(1);
        bus.req = '0;
        ack2 += int'(bus.ack[2]);
        for (int i = 0; i < 4; i++) begin
            step(1);
            ack2 += int'(bus.ack[2]);
        end
        chk("pulse_no_ack2", 32'(ack2), 0);
        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.req = N'($urandom);
            bus.req_data = 32'($urandom);
            force_full = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 2) == 0);
            step(1);
        end
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
